// File: rtl/regfile_access_ctrl.sv
// ----------------------------------------------------------------------------
// regfile_access_ctrl
//
// Purpose:
//   Serialises single-command accesses to an external register file that has
//   one write port (address/data/strobe) and one combinational read port.
//   A write is expanded into a setup / strobe / hold sequence so the register
//   file sees stable address and data around its one-cycle write strobe.
//   A write-verify performs the same write and then reads the register back,
//   flagging an error if the read-back differs from the written value.
//   Exactly one command is in flight at a time. Its response is held until
//   the consumer accepts it.
//
// Ports:
//   clk        - single clock, all state changes on the rising edge
//   reset      - synchronous, active-high reset
//   cmd_valid  - command offered
//   cmd_ready  - controller can accept a command (IDLE only)
//   cmd_op     - 00 read, 01 write, 10 write-verify, 11 reserved
//   cmd_addr   - target register address
//   cmd_wdata  - write value
//   rsp_valid  - response available (RESP state)
//   rsp_ready  - response consumed
//   rsp_rdata  - read data (0 for a plain write or reserved op)
//   rsp_err    - verify mismatch or reserved op
//   rf_mode    - register-file strobe: 1 = write, 0 = read
//   rf_waddr   - register-file write address
//   rf_wdata   - register-file write value
//   rf_raddr   - register-file read address
//   rf_rdata   - register-file combinational read value
// ----------------------------------------------------------------------------
module regfile_access_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rf_mode,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WSETUP,
        WPULSE,
        WHOLD,
        RADDR,
        RSAMPLE,
        RESP
    } state_t;

    localparam logic [1:0] OP_READ    = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_WVERIFY = 2'b10;
    localparam logic [1:0] OP_RSVD    = 2'b11;

    state_t state;
    state_t next_state;

    logic [1:0]        lat_op;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic accept;
    logic is_write_op;

    // cmd_ready is also gated by reset so that no command can appear accepted
    // during the reset edge itself; the state register alone would only drop
    // it one cycle later.
    assign cmd_ready   = (state == IDLE) && !reset;
    assign accept      = cmd_valid && cmd_ready;
    assign is_write_op = (cmd_op == OP_WRITE) || (cmd_op == OP_WVERIFY);

    // rsp_valid and rf_mode come straight from the state. A reset therefore
    // drops the write strobe and any pending response on the very next cycle.
    assign rsp_valid = (state == RESP);
    assign rf_mode   = (state == WPULSE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Each write phase and each read phase lasts a single
    // cycle. Only RESP waits, and it waits for the consumer's rsp_ready.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_READ:    next_state = RADDR;
                        OP_WRITE:   next_state = WSETUP;
                        OP_WVERIFY: next_state = WSETUP;
                        default:    next_state = RESP;
                    endcase
                end
            end
            WSETUP:  next_state = WPULSE;
            WPULSE:  next_state = WHOLD;
            WHOLD: begin
                if (lat_op == OP_WVERIFY) begin
                    next_state = RADDR;
                end else begin
                    next_state = RESP;
                end
            end
            RADDR:   next_state = RSAMPLE;
            RSAMPLE: next_state = RESP;
            RESP: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Command latch and register-file address/data drivers.
    // The write address and data are loaded at acceptance so they are already
    // stable during WSETUP. They stay stable through WPULSE and WHOLD, and
    // afterwards they keep their last value. The read address is loaded either
    // at acceptance of a read or as the write-verify leaves WHOLD. Either way,
    // rf_rdata has settled by the RSAMPLE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_op    <= 2'b00;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            rf_raddr  <= '0;
        end else begin
            if (accept) begin
                lat_op    <= cmd_op;
                lat_addr  <= cmd_addr;
                lat_wdata <= cmd_wdata;
                if (is_write_op) begin
                    rf_waddr <= cmd_addr;
                    rf_wdata <= cmd_wdata;
                end
                if (cmd_op == OP_READ) begin
                    rf_raddr <= cmd_addr;
                end
            end
            if ((state == WHOLD) && (lat_op == OP_WVERIFY)) begin
                rf_raddr <= lat_addr;
            end
        end
    end

    // Response payload.
    // The payload is cleared at acceptance, so a plain write returns 0 data.
    // A reserved op gets its error flag at that same point, because it goes
    // straight to RESP.
    // Reads and write-verifies capture the register-file data in RSAMPLE.
    // A write-verify also compares that data against the value it wrote.
    // Nothing changes the payload while in RESP, so it holds steady until it
    // is consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                rsp_rdata <= '0;
                rsp_err   <= (cmd_op == OP_RSVD);
            end else if (state == RSAMPLE) begin
                rsp_rdata <= rf_rdata;
                rsp_err   <= (lat_op == OP_WVERIFY) && (rf_rdata != lat_wdata);
            end
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// ----------------------------------------------------------------------------
// tb_regfile_access_ctrl
//
// Self-checking bench for regfile_access_ctrl. It contains a behavioural
// register file whose writes can be switched off to emulate a faulty array.
// Commands are driven and sampled on the falling edge. The expected response
// for each accepted command goes into a scoreboard queue and is popped when
// rsp_valid rises.
// ----------------------------------------------------------------------------
module tb_regfile_access_ctrl;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam logic [1:0] OP_READ    = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_WVERIFY = 2'b10;
    localparam logic [1:0] OP_RSVD    = 2'b11;

    logic              clk;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rf_mode;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [ADDR_W-1:0] rf_raddr;
    logic [DATA_W-1:0] rf_rdata;

    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic              err;
        int                lat;
        int                pulses;
    } exp_t;

    exp_t scoreboard[$];

    int test_count;
    int fail_count;

    logic [DATA_W-1:0] rf_mem [0:31];
    logic              drop_writes;

    regfile_access_ctrl #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .rf_mode   (rf_mode),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .rf_raddr  (rf_raddr),
        .rf_rdata  (rf_rdata)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural register file: the write happens on the edge that ends the
    // strobe cycle, and reads are combinational.
    always @(posedge clk) begin
        if (rf_mode && !drop_writes) begin
            rf_mem[rf_waddr] <= rf_wdata;
        end
    end

    assign rf_rdata = rf_mem[rf_raddr];

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Runs one full command/response handshake.
    // While the command is in flight, a garbage write stays offered on cmd_*,
    // and the controller must ignore it. The response is then held back for
    // hold_cycles before it is consumed.
    task automatic applyStimulus(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] wdata,
                                 input logic [DATA_W-1:0] exp_rdata, input logic exp_err,
                                 input int exp_lat, input int hold_cycles);
        exp_t e;
        int   lat;
        int   pulses;
        @(negedge clk);
        checkOutput("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        @(posedge clk);
        e.rdata  = exp_rdata;
        e.err    = exp_err;
        e.lat    = exp_lat;
        e.pulses = ((op == OP_WRITE) || (op == OP_WVERIFY)) ? 1 : 0;
        scoreboard.push_back(e);
        @(negedge clk);
        cmd_op    = OP_WRITE;
        cmd_addr  = ~addr;
        cmd_wdata = ~wdata;
        lat       = 1;
        pulses    = 0;
        while (!rsp_valid && lat < 20) begin
            if (rf_mode) pulses++;
            @(negedge clk);
            lat++;
        end
        e = scoreboard.pop_front();
        if (!rsp_valid) begin
            checkOutput("rsp_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        checkOutput("latency", lat, e.lat);
        checkOutput("rsp_rdata", rsp_rdata, e.rdata);
        checkOutput("rsp_err", rsp_err, e.err);
        checkOutput("rf_mode_pulses", pulses, e.pulses);
        for (int i = 0; i < hold_cycles; i++) begin
            @(negedge clk);
            checkOutput("hold_rsp_valid", rsp_valid, 1);
            checkOutput("hold_rsp_rdata", rsp_rdata, e.rdata);
            checkOutput("hold_rsp_err", rsp_err, e.err);
            checkOutput("hold_cmd_ready", cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("rsp_consumed", rsp_valid, 0);
        checkOutput("cmd_ready_after_rsp", cmd_ready, 1);
    endtask

    initial begin
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        int                n;
        logic              saw_rsp;

        test_count  = 0;
        fail_count  = 0;
        drop_writes = 1'b0;
        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = 2'b00;
        cmd_addr    = '0;
        cmd_wdata   = '0;
        rsp_ready   = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rf_mem[i] = 32'hA500_0000 | i;
        end

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("reset_cmd_ready", cmd_ready, 0);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 0);
        checkOutput("reset_rsp_err", rsp_err, 0);
        checkOutput("reset_rf_mode", rf_mode, 0);
        checkOutput("reset_rf_waddr", rf_waddr, 0);
        checkOutput("reset_rf_wdata", rf_wdata, 0);
        checkOutput("reset_rf_raddr", rf_raddr, 0);
        reset = 1'b0;
        #1;
        checkOutput("cmd_ready_after_reset", cmd_ready, 1);

        // Write then read back address 0.
        applyStimulus(OP_WRITE, 5'd0, 32'h0919_1232, 32'h0, 1'b0, 4, 0);
        applyStimulus(OP_READ, 5'd0, 32'h0, 32'h0919_1232, 1'b0, 3, 0);

        // Write-verify against a working array.
        applyStimulus(OP_WVERIFY, 5'd1, 32'h0931_9232, 32'h0931_9232, 1'b0, 6, 1);

        // Write-verify against an array that drops writes: the old contents come back.
        drop_writes = 1'b1;
        applyStimulus(OP_WVERIFY, 5'd2, 32'h5035_9232, 32'hA500_0002, 1'b1, 6, 0);
        drop_writes = 1'b0;

        // Top address, with back-pressure on the response.
        applyStimulus(OP_READ, 5'd31, 32'h0, 32'hA500_001F, 1'b0, 3, 5);

        // Reserved op.
        applyStimulus(OP_RSVD, 5'd7, 32'h1234_5678, 32'h0, 1'b1, 1, 2);

        // Random write/read-back pairs and write-verifies.
        for (int i = 0; i < 4; i++) begin
            a = 5'($urandom_range(3, 31));
            d = $urandom;
            applyStimulus(OP_WRITE, a, d, 32'h0, 1'b0, 4, 0);
            applyStimulus(OP_READ, a, 32'h0, d, 1'b0, 3, i);
            d = $urandom;
            applyStimulus(OP_WVERIFY, a, d, d, 1'b0, 6, 0);
        end

        // Reset hitting the write strobe cycle.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_WRITE;
        cmd_addr  = 5'd5;
        cmd_wdata = 32'hDEAD_0005;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!rf_mode && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wpulse_reached", rf_mode, 1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("wpulse_reset_rf_mode", rf_mode, 0);
        checkOutput("wpulse_reset_rsp_valid", rsp_valid, 0);
        checkOutput("wpulse_reset_cmd_ready", cmd_ready, 0);
        checkOutput("wpulse_reset_rf_waddr", rf_waddr, 0);
        checkOutput("wpulse_reset_rf_wdata", rf_wdata, 0);
        reset = 1'b0;
        #1;
        checkOutput("wpulse_reset_cmd_ready_after", cmd_ready, 1);
        saw_rsp = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid || rf_mode) saw_rsp = 1'b1;
        end
        checkOutput("wpulse_reset_no_response", saw_rsp, 0);

        // The controller still works after the aborted write.
        applyStimulus(OP_READ, 5'd0, 32'h0, 32'h0919_1232, 1'b0, 3, 0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

    // Global watchdog so a hung DUT can never stall the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/regfile_access_ctrl.md
REGFILE_ACCESS_CTRL -- requirements
Module: regfile_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, register-file address width.
REQ-002 SHALL have parameter DATA_W, default 32, register-file data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high at a rising edge.
REQ-007 SHALL have port cmd_op  input  2  00 = read, 01 = write, 10 = write-verify, 11 = reserved.
REQ-008 SHALL have port cmd_addr  input  ADDR_W  target register.
REQ-009 SHALL have port cmd_wdata  input  DATA_W  write value.
REQ-010 SHALL have port rsp_valid  output  1  response available.
REQ-011 SHALL have port rsp_ready  input  1  response consumed when rsp_valid and rsp_ready are both high at a rising edge.
REQ-012 SHALL have port rsp_rdata  output  DATA_W  read data; 0 for a plain write.
REQ-013 SHALL have port rsp_err  output  1  verify mismatch or reserved op.
REQ-014 SHALL have port rf_mode  output  1  register-file mode: 0 = read, 1 = write.
REQ-015 SHALL have port rf_waddr  output  ADDR_W  register-file write address.
REQ-016 SHALL have port rf_wdata  output  DATA_W  register-file write value.
REQ-017 SHALL have port rf_raddr  output  ADDR_W  register-file read address.
REQ-018 SHALL have port rf_rdata  input  DATA_W  register-file combinational read value.

Function
REQ-019 SHALL implement the FSM states IDLE, WSETUP, WPULSE, WHOLD, RADDR, RSAMPLE and RESP.
REQ-020 SHALL assert cmd_ready only in IDLE, so at most one command is in flight.
REQ-021 SHALL latch cmd_op, cmd_addr and cmd_wdata on acceptance.
REQ-022 SHALL transition from IDLE on acceptance as follows: read -> RADDR; write or write-verify -> WSETUP; reserved op -> RESP with rsp_err = 1 and rsp_rdata = 0.
REQ-023 SHALL drive, in WSETUP, rf_waddr and rf_wdata to the latched values with rf_mode = 0, for 1 cycle.
REQ-024 SHALL drive rf_mode = 1 in WPULSE, for exactly 1 cycle, with rf_waddr and rf_wdata unchanged.
REQ-025 SHALL hold rf_waddr and rf_wdata in WHOLD with rf_mode = 0, for 1 cycle.
REQ-026 SHALL transition from WHOLD to RESP for a plain write, and to RADDR for a write-verify.
REQ-027 SHALL drive rf_raddr to the latched address in RADDR, with rf_mode = 0, for 1 cycle.
REQ-028 SHALL register rf_rdata into rsp_rdata in RSAMPLE, then go to RESP.
REQ-029 SHALL, for a write-verify, set rsp_err = 1 in RSAMPLE if the sampled value differs from the latched wdata, otherwise 0.
REQ-030 SHALL give latency from acceptance edge to first rsp_valid = 1 of: read 3 cycles; write 4 cycles; write-verify 6 cycles; reserved op 1 cycle.
REQ-031 SHALL hold rsp_valid = 1 in RESP, with rsp_rdata and rsp_err stable, until rsp_ready = 1; then return to IDLE.
REQ-032 SHALL not accept a new command in the cycle a response is consumed; cmd_ready rises the following cycle.
REQ-033 SHALL assert rf_mode only in WPULSE; in every other state rf_mode = 0.
REQ-034 SHALL hold rf_raddr and rf_waddr at their last driven value when not in use.
REQ-035 SHALL ignore cmd_* inputs while not in IDLE.
REQ-036 SHALL treat address wrap as a non-event: any ADDR_W value is legal, with no boundary handling.

Reset
REQ-037 SHALL, while reset = 1 at a rising edge, enter IDLE and set rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, rf_mode = 0, rf_waddr = 0, rf_wdata = 0, rf_raddr = 0, and all latched command fields to 0.
REQ-038 SHALL, on reset during any state (including WPULSE), force rf_mode = 0 from the next cycle, discard the in-flight command, and produce no response for it.
REQ-039 SHALL keep cmd_ready = 0 while reset = 1; cmd_ready = 1 in the first cycle after reset deasserts.

Verification
REQ-040 SHALL cover: write addr 0 with 0x0919_1232, then read addr 0 -> rf_mode high exactly 1 cycle; read response rdata = 0x0919_1232, err = 0.
REQ-041 SHALL cover: write-verify addr 1 with 0x0931_9232 against a correct register-file model -> rsp after 6 cycles with rdata = 0x0931_9232, err = 0.
REQ-042 SHALL cover: write-verify addr 2 with 0x5035_9232 against a model that drops writes -> err = 1, rdata = old contents.
REQ-043 SHALL cover: read addr 31 with rsp_ready held low for 5 cycles -> rsp_valid stays high, rdata stable, cmd_ready low throughout.
REQ-044 SHALL cover: cmd_op = 11 -> rsp after 1 cycle with err = 1, rdata = 0, and rf_mode never asserted.
REQ-045 SHALL cover: reset asserted in WPULSE -> rf_mode = 0 next cycle, no rsp_valid, cmd_ready = 1 the cycle after reset deasserts.
